// File: rtl/jt51_mixacc.sv
// rtl/jt51_mixacc.sv - per-slot channel summing, L/R frame mixing, attenuation and clamping
// Channel sums saturate at OUTW bits; frame sums carry GUARD extra bits and clamp only at output.
module jt51_mixacc #(
   parameter int CH    = 8,
   parameter int OPW   = 14,
   parameter int OUTW  = 16,
   parameter int GUARD = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cen,
   input  logic signed [OPW-1:0]  op_val,
   input  logic                   sum_en,
   input  logic                   ch_last,
   input  logic                   frame_start,
   input  logic [1:0]             rl,
   input  logic [1:0]             att,
   input  logic                   clip_clr,
   output logic signed [OUTW-1:0] left,
   output logic signed [OUTW-1:0] right,
   output logic                   sample_vld,
   output logic                   clip_l,
   output logic                   clip_r,
   output logic                   frame_err
);

   localparam int CW = $clog2(CH) + 1;
   localparam int FW = OUTW + GUARD;

   localparam logic signed [OUTW-1:0] OMAX = {1'b0, {(OUTW-1){1'b1}}};
   localparam logic signed [OUTW-1:0] OMIN = {1'b1, {(OUTW-1){1'b0}}};
   localparam logic signed [FW-1:0]   FMAX = {{GUARD{1'b0}}, OMAX};
   localparam logic signed [FW-1:0]   FMIN = {{GUARD{1'b1}}, OMIN};
   localparam logic [CW-1:0]          CNT_MAX = '1;
   localparam logic [CW-1:0]          CNT_EXP = CW'(CH);

   logic signed [OUTW-1:0] chs_q, chs_d;
   logic signed [FW-1:0]   facc_l_q, facc_l_d, facc_r_q, facc_r_d;
   logic [CW-1:0]          ch_cnt_q, ch_cnt_d;
   logic                   first_q;
   logic                   armed_q;
   logic signed [OUTW-1:0] left_q, left_d, right_q, right_d;
   logic                   vld_q;
   logic                   clip_l_q, clip_l_d, clip_r_q, clip_r_d;
   logic                   ferr_q, ferr_d;

   // {clamp engaged, clamped value}
   function automatic logic [OUTW:0] clamp_f(input logic signed [FW-1:0] v);
      if (v > FMAX)
         return {1'b1, OMAX};
      else if (v < FMIN)
         return {1'b1, OMIN};
      else
         return {1'b0, v[OUTW-1:0]};
   endfunction

   logic signed [OUTW-1:0] ch_base;
   logic signed [OUTW:0]   ch_add;
   logic signed [OUTW:0]   op_ext;
   logic signed [FW-1:0]   ch_tot_ext;
   logic signed [FW-1:0]   fl_base, fr_base;
   logic [CW-1:0]          cnt_base;
   logic [OUTW:0]          cl_l, cl_r;

   always_comb begin
      op_ext  = {{(OUTW+1-OPW){op_val[OPW-1]}}, op_val};
      ch_base = (first_q || frame_start) ? '0 : chs_q;
      ch_add  = {ch_base[OUTW-1], ch_base} + op_ext;
      chs_d   = ch_base;
      if (sum_en) begin
         if (ch_add[OUTW] != ch_add[OUTW-1])
            chs_d = ch_add[OUTW] ? OMIN : OMAX;
         else
            chs_d = ch_add[OUTW-1:0];
      end
   end

   // The channel total is the updated sum, so a ch_last slot's own operator is included.
   always_comb begin
      ch_tot_ext = {{GUARD{chs_d[OUTW-1]}}, chs_d};
      fl_base    = frame_start ? '0 : facc_l_q;
      fr_base    = frame_start ? '0 : facc_r_q;
      facc_l_d   = fl_base;
      facc_r_d   = fr_base;
      if (ch_last && rl[0]) facc_l_d = fl_base + ch_tot_ext;
      if (ch_last && rl[1]) facc_r_d = fr_base + ch_tot_ext;
   end

   always_comb begin
      cnt_base = frame_start ? '0 : ch_cnt_q;
      ch_cnt_d = cnt_base;
      if (ch_last && cnt_base != CNT_MAX)
         ch_cnt_d = cnt_base + CW'(1);
   end

   always_comb begin
      cl_l     = clamp_f(facc_l_q >>> att);
      cl_r     = clamp_f(facc_r_q >>> att);
      left_d   = left_q;
      right_d  = right_q;
      ferr_d   = ferr_q;
      clip_l_d = clip_clr ? 1'b0 : clip_l_q;
      clip_r_d = clip_clr ? 1'b0 : clip_r_q;
      if (frame_start) begin
         left_d  = cl_l[OUTW-1:0];
         right_d = cl_r[OUTW-1:0];
         if (cl_l[OUTW]) clip_l_d = 1'b1;
         if (cl_r[OUTW]) clip_r_d = 1'b1;
         if (armed_q) ferr_d = (ch_cnt_q != CNT_EXP);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chs_q    <= '0;
         facc_l_q <= '0;
         facc_r_q <= '0;
         ch_cnt_q <= '0;
         first_q  <= 1'b1;
         armed_q  <= 1'b0;
         left_q   <= '0;
         right_q  <= '0;
         vld_q    <= 1'b0;
         clip_l_q <= 1'b0;
         clip_r_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         // Strobe is refreshed every clk so it never stretches across cen=0 cycles.
         vld_q <= cen && frame_start;
         if (cen) begin
            chs_q    <= chs_d;
            facc_l_q <= facc_l_d;
            facc_r_q <= facc_r_d;
            ch_cnt_q <= ch_cnt_d;
            first_q  <= ch_last;
            armed_q  <= armed_q || frame_start;
            left_q   <= left_d;
            right_q  <= right_d;
            clip_l_q <= clip_l_d;
            clip_r_q <= clip_r_d;
            ferr_q   <= ferr_d;
         end
      end
   end

   assign left       = left_q;
   assign right      = right_q;
   assign sample_vld = vld_q;
   assign clip_l     = clip_l_q;
   assign clip_r     = clip_r_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_jt51_mixacc.sv
// tb/tb_jt51_mixacc.sv - directed-vector bench for jt51_mixacc with hand-computed expectations
module tb_jt51_mixacc;

   logic               clk = 1'b0;
   logic               rst, cen;
   logic signed [13:0] op_val;
   logic               sum_en, ch_last, frame_start, clip_clr;
   logic [1:0]         rl, att;
   logic signed [15:0] left, right;
   logic               sample_vld, clip_l, clip_r, frame_err;

   int n_chk  = 0;
   int n_fail = 0;
   int gap    = 0;

   jt51_mixacc dut (
      .clk(clk), .rst(rst), .cen(cen), .op_val(op_val), .sum_en(sum_en),
      .ch_last(ch_last), .frame_start(frame_start), .rl(rl), .att(att),
      .clip_clr(clip_clr), .left(left), .right(right), .sample_vld(sample_vld),
      .clip_l(clip_l), .clip_r(clip_r), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs are held through 'gap' cen=0 cycles before the single enabled edge.
   task automatic slot(input int op, input bit se, input bit cl, input bit fs,
                       input bit [1:0] r, input bit [1:0] a, input bit cc);
      op_val      = 14'(op);
      sum_en      = se;
      ch_last     = cl;
      frame_start = fs;
      rl          = r;
      att         = a;
      clip_clr    = cc;
      for (int g = 0; g < gap; g++) begin
         cen = 1'b0;
         @(posedge clk);
         #1;
      end
      cen = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic body(input int nch, input int nops, input int op, input bit [1:0] r);
      for (int c = 0; c < nch; c++)
         for (int s = 0; s < nops; s++)
            slot(op, 1'b1, s == nops - 1, 1'b0, r, 2'b00, 1'b0);
   endtask

   task automatic fstart(input bit [1:0] a, input bit cc);
      slot(0, 1'b0, 1'b0, 1'b1, 2'b00, a, cc);
   endtask

   task automatic idle();
      cen = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; cen = 1'b0; op_val = '0; sum_en = 1'b0; ch_last = 1'b0;
      frame_start = 1'b0; rl = 2'b00; att = 2'b00; clip_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_left", left, 0);
      check("rst_right", right, 0);
      check("rst_vld", sample_vld, 0);
      check("rst_clip_l", clip_l, 0);
      check("rst_clip_r", clip_r, 0);
      check("rst_ferr", frame_err, 0);
      rst = 1'b0;

      // Scenario 1: 8 ch x 4 slots x 100, both sides
      fstart(2'd0, 1'b0);
      check("s1_first_vld", sample_vld, 1);
      check("s1_first_ferr", frame_err, 0);
      body(8, 4, 100, 2'b11);
      fstart(2'd0, 1'b0);
      check("s1_vld", sample_vld, 1);
      check("s1_left", left, 3200);
      check("s1_right", right, 3200);
      check("s1_ferr", frame_err, 0);
      idle();
      check("s1_vld_off", sample_vld, 0);

      // Scenario 2: near full-scale channels, output clamp and clip_clr
      body(1, 4, 8191, 2'b01);
      fstart(2'd0, 1'b0);
      check("s2_one_left", left, 32764);
      check("s2_one_right", right, 0);
      check("s2_one_ferr", frame_err, 1);
      check("s2_one_clip_l", clip_l, 0);
      body(8, 4, 8191, 2'b01);
      fstart(2'd3, 1'b0);
      check("s2_att3_left", left, 32764);
      check("s2_att3_clip_l", clip_l, 0);
      check("s2_att3_ferr", frame_err, 0);
      body(8, 4, 8191, 2'b01);
      fstart(2'd0, 1'b0);
      check("s2_sat_left", left, 32767);
      check("s2_sat_clip_l", clip_l, 1);
      check("s2_sat_right", right, 0);
      check("s2_sat_clip_r", clip_r, 0);
      slot(0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      check("s2_clr_clip_l", clip_l, 0);
      check("s2_clr_left", left, 32767);
      body(1, 5, 8191, 2'b10);
      fstart(2'd0, 1'b0);
      check("s2_chsat_right", right, 32767);
      check("s2_chsat_clip_r", clip_r, 0);
      check("s2_chsat_left", left, 0);

      // Scenario 3: negative sums with att=2
      body(1, 4, -8192, 2'b01);
      body(1, 1, -8192, 2'b01);
      fstart(2'd2, 1'b0);
      check("s3_left", left, -10240);
      check("s3_right", right, 0);
      check("s3_clip_l", clip_l, 0);
      check("s3_ferr", frame_err, 1);
      body(8, 4, -8192, 2'b01);
      fstart(2'd0, 1'b1);
      check("s3_neg_left", left, -32768);
      check("s3_clamp_beats_clr", clip_l, 1);
      slot(0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      check("s3_clr_clip_l", clip_l, 0);

      // Scenario 4: channel-count checking
      body(7, 4, 100, 2'b11);
      fstart(2'd0, 1'b0);
      check("s4_short_ferr", frame_err, 1);
      check("s4_short_left", left, 2800);
      body(8, 4, 100, 2'b11);
      fstart(2'd0, 1'b0);
      check("s4_ok_ferr", frame_err, 0);
      check("s4_ok_left", left, 3200);
      body(24, 1, 1, 2'b11);
      fstart(2'd0, 1'b0);
      check("s4_cntsat_ferr", frame_err, 1);
      check("s4_cntsat_right", right, 24);

      // Scenario 5: cen 1:3 with frame_start/ch_last held through disabled cycles
      gap = 3;
      body(8, 4, 100, 2'b11);
      fstart(2'd0, 1'b0);
      check("s5_vld", sample_vld, 1);
      check("s5_left", left, 3200);
      check("s5_right", right, 3200);
      check("s5_ferr", frame_err, 0);
      gap = 0;
      idle();
      check("s5_vld_width", sample_vld, 0);
      check("s5_left_hold", left, 3200);

      // Scenario 6: reset mid-frame
      body(2, 4, 100, 2'b11);
      fstart(2'd0, 1'b0);
      check("s6_pre_ferr", frame_err, 1);
      check("s6_pre_left", left, 800);
      body(3, 4, 100, 2'b11);
      rst = 1'b1; cen = 1'b1; frame_start = 1'b1; ch_last = 1'b1; sum_en = 1'b1;
      @(posedge clk);
      #1;
      check("s6_rst_left", left, 0);
      check("s6_rst_right", right, 0);
      check("s6_rst_vld", sample_vld, 0);
      check("s6_rst_ferr", frame_err, 0);
      check("s6_rst_clip_l", clip_l, 0);
      rst = 1'b0;
      fstart(2'd0, 1'b0);
      check("s6_post_vld", sample_vld, 1);
      check("s6_post_left", left, 0);
      check("s6_post_right", right, 0);
      check("s6_post_ferr", frame_err, 0);
      body(5, 4, 100, 2'b11);
      fstart(2'd0, 1'b0);
      check("s6_armed_ferr", frame_err, 1);
      check("s6_armed_left", left, 2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/jt51_mixacc.md
JT51_MIXACC -- requirements
Module: jt51_mixacc

Interface
REQ-001 SHALL have parameter CH, default 8: channels per frame.
REQ-002 SHALL have parameter OPW, default 14: operator sample width, two's complement.
REQ-003 SHALL have parameter OUTW, default 16: channel-sum and output width.
REQ-004 SHALL have parameter GUARD, default 4: frame-accumulator headroom bits, with GUARD >= clog2(CH) required.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port cen, input, 1: slot enable. All state advances only on clk edges with cen=1, except where REQ-023 says otherwise.
REQ-008 SHALL have port op_val, input, OPW, signed: operator output for the current slot.
REQ-009 SHALL have port sum_en, input, 1: the current slot contributes to its channel sum.
REQ-010 SHALL have port ch_last, input, 1: the current slot is the final operator slot of a channel.
REQ-011 SHALL have port frame_start, input, 1: the current slot is the first slot of a frame.
REQ-012 SHALL have port rl, input, 2: channel pan, where bit1 = right enable and bit0 = left enable; it is sampled on ch_last.
REQ-013 SHALL have port att, input, 2: output attenuation, an arithmetic right shift of 0..3, sampled on frame_start.
REQ-014 SHALL have port clip_clr, input, 1: clears clip flags.
REQ-015 SHALL have ports left and right, output, OUTW, signed: registered frame outputs.
REQ-016 SHALL have port sample_vld, output, 1: new-sample strobe.
REQ-017 SHALL have ports clip_l and clip_r, output, 1: sticky output-clamp flags.
REQ-018 SHALL have port frame_err, output, 1: channel-count mismatch flag.

Function
REQ-019 SHALL hold a channel accumulator chs, OUTW bits.
- On the first slot of a channel (the slot after a ch_last, or any frame_start slot): chs <= sum_en ? sext(op_val) : 0.
- On any other slot with sum_en: chs <= sat_OUTW(chs + sext(op_val)).
- On any other slot without sum_en: chs holds.
REQ-020 SHALL define the channel total on a ch_last slot as the REQ-019 value including that slot's own contribution.
REQ-021 SHALL hold frame accumulators facc_l and facc_r, each OUTW+GUARD bits. On ch_last: facc_x <= facc_x + (pan bit ? sext(channel total) : 0). These accumulators never wrap, given REQ-004.
REQ-022 SHALL, on frame_start, do all of the following:
- left/right <= clamp_OUTW(facc_x >>> att);
- facc_x restarts with this slot's contribution only; it is 0 unless ch_last is also set;
- the channel counter restarts in the same way.
REQ-023 SHALL pulse sample_vld high for exactly one clk cycle, coinciding with the cycle in which left/right first show the new value (one clk after the frame_start slot). This pulse is independent of cen in the following cycle.
REQ-024 SHALL clamp to max positive 2^(OUTW-1)-1 or min negative -2^(OUTW-1). When clamping engages for a channel, it SHALL set that channel's clip flag (clip_l or clip_r), which stays set until clip_clr or rst.
REQ-025 SHALL let a clamp event win when clip_clr and a clamp event occur on the same cen edge, so the flag ends up 1.
REQ-026 SHALL count ch_last pulses per frame in ch_cnt, saturating at 2^(clog2(CH)+1)-1.
REQ-027 SHALL, on each frame_start after the first one following reset, set frame_err <= (ch_cnt != CH); frame_err reflects the most recent check.
REQ-028 SHALL ignore frame_start and ch_last while cen=0.

Reset
REQ-029 SHALL, on rst, set left, right, sample_vld, clip_l, clip_r, frame_err, chs, facc_l, facc_r and ch_cnt to 0, and disarm the frame_err check.
REQ-030 SHALL give rst priority over cen and all other inputs. A frame in progress when rst asserts is discarded, and no sample_vld is produced for it.

Verification
REQ-031 SHALL be verified by the following directed scenarios:
- Scenario 1: CH=8, 4 slots/channel, op_val=100 with sum_en on all slots, rl=2'b11, att=0, two frames -> second sample_vld gives left=right=3200, frame_err=0.
- Scenario 2: one channel with op_val=8191 on 4 slots, OUTW=16 -> chs=32764 (no saturation). Then 8 such channels panned left -> facc_l=262112, left=32767, clip_l=1, right=0, clip_r=0. Then clip_clr -> clip_l=0.
- Scenario 3: channel ops -8192 × 4 plus a channel with -8192 on 1 slot, left only, att=2 -> left = (-32768-8192)>>>2 = -10240, no clip.
- Scenario 4: a frame with only 7 ch_last pulses -> frame_err=1 at the next frame_start. A following correct frame -> frame_err=0. The first frame after reset -> frame_err=0 regardless of count.
- Scenario 5: cen toggling 1:3 during a frame -> same outputs as scenario 1; sample_vld exactly one clk wide.
- Scenario 6: rst asserted mid-frame -> all outputs 0 the next clk. The first post-reset frame_start produces left=right=0 and does not check frame_err.
